hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage RV32I core; companion to the operand forwarding unit.
- Detects the hazards that forwarding cannot cover: load-use, taken branch/jump, instruction-memory wait and data-memory wait.
- Drives the per-stage register load enables, bubble/flush controls and PC load.
- Keeps saturating stall and flush counters for performance monitoring.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/hz_perf_cnt.sv | 31 +++
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN,
        DWAIT,
        RPEND,
        DRPEND
    } hz_state_e;

    typedef struct packed {
        logic ld_pc;
        logic ld_if_id;
        logic flush_if_id;
        logic ld_id_ex;
        logic bubble_id_ex;
        logic ld_ex_mem;
        logic ld_mem_wb;
    } stage_ctrl_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hz_perf_cnt.sv
// Saturating event counter used for pipeline performance monitoring.
module hz_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use, redirect and memory-wait hazards,
// per-stage load/flush controls and stall/flush performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_br_taken,
    input  logic             mem_dreq,
    input  logic             dmem_resp,
    input  logic             imem_resp,
    output logic             imem_read,
    output logic             ld_pc,
    output logic             pc_sel_tgt,
    output logic             tgt_capture,
    output logic             ld_if_id,
    output logic             flush_if_id,
    output logic             ld_id_ex,
    output logic             bubble_id_ex,
    output logic             ld_ex_mem,
    output logic             ld_mem_wb,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_e   state_q, state_d;
    stage_ctrl_t sc;
    logic        lu;
    logic        dstall;
    logic        pend;
    logic        redirect_done;

    assign lu = ex_valid && ex_is_load && (ex_rd != REG_ZERO) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                 (id_use_rs2 && (id_rs2 == ex_rd)));

    assign dstall = mem_dreq && !dmem_resp;
    assign pend   = (state_q == RPEND) || (state_q == DRPEND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sc            = '0;
        pc_sel_tgt    = 1'b0;
        tgt_capture   = 1'b0;
        redirect_done = 1'b0;

        if (dstall) begin
            // Whole pipe frozen; remember whether a redirect is still owed.
            if (state_q == RUN)   state_d = DWAIT;
            if (state_q == RPEND) state_d = DRPEND;
        end else if (pend) begin
            sc.ld_if_id    = 1'b1;
            sc.flush_if_id = 1'b1;
            sc.ld_id_ex    = 1'b1;
            sc.ld_ex_mem   = 1'b1;
            sc.ld_mem_wb   = 1'b1;
            if (imem_resp) begin
                sc.ld_pc      = 1'b1;
                pc_sel_tgt    = 1'b1;
                redirect_done = 1'b1;
                state_d       = RUN;
            end else begin
                state_d       = RPEND;
            end
        end else begin
            // RUN, or DWAIT released this cycle by dmem_resp.
            state_d      = RUN;
            sc.ld_ex_mem = 1'b1;
            sc.ld_mem_wb = 1'b1;
            if (ex_br_taken) begin
                sc.ld_if_id     = 1'b1;
                sc.flush_if_id  = 1'b1;
                sc.ld_id_ex     = 1'b1;
                sc.bubble_id_ex = 1'b1;
                if (imem_resp) begin
                    sc.ld_pc      = 1'b1;
                    pc_sel_tgt    = 1'b1;
                    redirect_done = 1'b1;
                end else begin
                    tgt_capture   = 1'b1;
                    state_d       = RPEND;
                end
            end else if (lu) begin
                sc.ld_id_ex     = 1'b1;
                sc.bubble_id_ex = 1'b1;
            end else if (!imem_resp) begin
                sc.ld_if_id    = 1'b1;
                sc.flush_if_id = 1'b1;
                sc.ld_id_ex    = 1'b1;
            end else begin
                sc.ld_pc    = 1'b1;
                sc.ld_if_id = 1'b1;
                sc.ld_id_ex = 1'b1;
            end
        end
    end

    assign imem_read    = 1'b1;
    assign ld_pc        = sc.ld_pc;
    assign ld_if_id     = sc.ld_if_id;
    assign flush_if_id  = sc.flush_if_id;
    assign ld_id_ex     = sc.ld_id_ex;
    assign bubble_id_ex = sc.bubble_id_ex;
    assign ld_ex_mem    = sc.ld_ex_mem;
    assign ld_mem_wb    = sc.ld_mem_wb;

    hz_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (!sc.ld_pc),
        .cnt_o (stall_cnt)
    );

    hz_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (redirect_done),
        .cnt_o (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: per-cycle expected controls and counters.
module tb_hazard_ctrl;

    localparam int unsigned CNT_W = 32;

    // {ld_pc, pc_sel_tgt, tgt_capture, ld_if_id, flush_if_id, ld_id_ex, bubble_id_ex, ld_ex_mem, ld_mem_wb, imem_read}
    localparam logic [9:0] E_RUN  = 10'b1_0_0_1_0_1_0_1_1_1;
    localparam logic [9:0] E_LU   = 10'b0_0_0_0_0_1_1_1_1_1;
    localparam logic [9:0] E_BRH  = 10'b1_1_0_1_1_1_1_1_1_1;
    localparam logic [9:0] E_BRM  = 10'b0_0_1_1_1_1_1_1_1_1;
    localparam logic [9:0] E_RP   = 10'b0_0_0_1_1_1_0_1_1_1;
    localparam logic [9:0] E_RPD  = 10'b1_1_0_1_1_1_0_1_1_1;
    localparam logic [9:0] E_DST  = 10'b0_0_0_0_0_0_0_0_0_1;
    localparam logic [9:0] E_FS   = 10'b0_0_0_1_1_1_0_1_1_1;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       exv;
        logic       ld;
        logic [4:0] rd;
        logic       br;
        logic       dreq;
        logic       dresp;
        logic       iresp;
    } stim_t;

    typedef struct packed {
        logic [9:0]       outs;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, ex_valid, ex_is_load, ex_br_taken;
    logic             mem_dreq, dmem_resp, imem_resp;
    logic             imem_read, ld_pc, pc_sel_tgt, tgt_capture, ld_if_id, flush_if_id;
    logic             ld_id_ex, bubble_id_ex, ld_ex_mem, ld_mem_wb;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [9:0]       obs;

    exp_t             sb_q[$];
    int unsigned      n_chk = 0;
    int unsigned      n_pass = 0;
    logic [CNT_W-1:0] exp_stall = '0;
    logic [CNT_W-1:0] exp_flush = '0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_valid     (ex_valid),
        .ex_is_load   (ex_is_load),
        .ex_rd        (ex_rd),
        .ex_br_taken  (ex_br_taken),
        .mem_dreq     (mem_dreq),
        .dmem_resp    (dmem_resp),
        .imem_resp    (imem_resp),
        .imem_read    (imem_read),
        .ld_pc        (ld_pc),
        .pc_sel_tgt   (pc_sel_tgt),
        .tgt_capture  (tgt_capture),
        .ld_if_id     (ld_if_id),
        .flush_if_id  (flush_if_id),
        .ld_id_ex     (ld_id_ex),
        .bubble_id_ex (bubble_id_ex),
        .ld_ex_mem    (ld_ex_mem),
        .ld_mem_wb    (ld_mem_wb),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    assign obs = {ld_pc, pc_sel_tgt, tgt_capture, ld_if_id, flush_if_id,
                  ld_id_ex, bubble_id_ex, ld_ex_mem, ld_mem_wb, imem_read};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.iresp = 1'b1;
        return s;
    endfunction

    function automatic stim_t load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1);
        stim_t s;
        s     = idle();
        s.exv = 1'b1;
        s.ld  = 1'b1;
        s.rd  = rd;
        s.rs1 = rs1;
        s.u1  = u1;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        id_rs1      = s.rs1;
        id_rs2      = s.rs2;
        id_use_rs1  = s.u1;
        id_use_rs2  = s.u2;
        ex_valid    = s.exv;
        ex_is_load  = s.ld;
        ex_rd       = s.rd;
        ex_br_taken = s.br;
        mem_dreq    = s.dreq;
        dmem_resp   = s.dresp;
        imem_resp   = s.iresp;
    endtask

    // Drive one cycle, push its expectation, score at the following negedge.
    task automatic step(input string tag, input stim_t s, input logic [9:0] e);
        exp_t x;
        apply(s);
        x.outs  = e;
        x.stall = exp_stall;
        x.flush = exp_flush;
        sb_q.push_back(x);
        if (rst_n) begin
            if (!e[9])        exp_stall = exp_stall + 1'b1;
            if (e[9] && e[8]) exp_flush = exp_flush + 1'b1;
        end
        @(negedge clk);
        x = sb_q.pop_front();
        check_val(tag, 32'(obs), 32'(x.outs));
        check_val({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(x.stall));
        check_val({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(x.flush));
        @(posedge clk);
        #1;
    endtask

    initial begin
        stim_t s;
        rst_n = 1'b0;
        apply(idle());
        step("reset", idle(), E_RUN);
        rst_n = 1'b1;
        step("idle0", idle(), E_RUN);

        step("lu_rs1", load_use(5'd5, 5'd5, 1'b1), E_LU);
        step("lu_after", idle(), E_RUN);
        step("lu_rd0", load_use(5'd0, 5'd0, 1'b1), E_RUN);
        step("lu_nouse", load_use(5'd5, 5'd5, 1'b0), E_RUN);
        step("lu_nomatch", load_use(5'd5, 5'd6, 1'b1), E_RUN);
        s = load_use(5'd7, 5'd1, 1'b0);
        s.rs2 = 5'd7;
        s.u2  = 1'b1;
        step("lu_rs2", s, E_LU);
        s.ld = 1'b0;
        step("nonload", s, E_RUN);

        s = idle();
        s.br = 1'b1;
        step("br_hit", s, E_BRH);
        step("br_hit_after", idle(), E_RUN);

        s = idle();
        s.br    = 1'b1;
        s.iresp = 1'b0;
        step("br_miss", s, E_BRM);
        s = idle();
        s.iresp = 1'b0;
        step("rpend1", s, E_RP);
        step("rpend2", s, E_RP);
        step("rpend_done", idle(), E_RPD);
        step("rpend_after", idle(), E_RUN);

        s = load_use(5'd9, 5'd9, 1'b1);
        s.dreq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step($sformatf("dstall%0d", i), s, E_DST);
        end
        s.dresp = 1'b1;
        step("dstall_rel_lu", s, E_LU);
        step("dstall_after", idle(), E_RUN);

        s = idle();
        s.br    = 1'b1;
        s.iresp = 1'b0;
        step("drp_brmiss", s, E_BRM);
        s = idle();
        s.dreq = 1'b1;
        step("drp_wait", s, E_DST);
        s.dresp = 1'b1;
        step("drp_release", s, E_RPD);
        step("drp_after", idle(), E_RUN);

        s = load_use(5'd3, 5'd3, 1'b1);
        s.br = 1'b1;
        step("br_over_lu", s, E_BRH);
        s = load_use(5'd3, 5'd3, 1'b1);
        s.iresp = 1'b0;
        step("lu_fetchstall", s, E_LU);
        s = idle();
        s.iresp = 1'b0;
        step("fetchstall", s, E_FS);
        step("fs_after", idle(), E_RUN);

        s = idle();
        s.br    = 1'b1;
        s.iresp = 1'b0;
        step("rst_brmiss", s, E_BRM);
        s = idle();
        s.iresp = 1'b0;
        step("rst_rpend", s, E_RP);
        rst_n = 1'b0;
        #1;
        check_val("async_rst.stall_cnt", 32'(stall_cnt), 32'd0);
        check_val("async_rst.flush_cnt", 32'(flush_cnt), 32'd0);
        exp_stall = '0;
        exp_flush = '0;
        step("rst_hold", idle(), E_RUN);
        rst_n = 1'b1;
        step("rst_release", idle(), E_RUN);
        step("rst_release2", idle(), E_RUN);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
